// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the memory-port arbiter: FSM state encoding,
// requester select, and the data-streak limit that forces a fetch grant.
package mem_port_arbiter_pkg;

   localparam int WORD_SIZE_DEF   = 16;
   localparam int MEM_LATENCY_DEF = 2;
   localparam int STREAK_W        = 2;

   localparam logic [STREAK_W-1:0] STREAK_LIMIT = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_FETCH = 1'b0,
      REQ_DATA  = 1'b1
   } req_sel_t;

   // Saturating streak update applied on every grant.
   function automatic logic [STREAK_W-1:0] streak_next(
      input logic [STREAK_W-1:0] cur,
      input req_sel_t            sel,
      input logic                fetch_pending
   );
      logic [STREAK_W-1:0] nxt;
      nxt = '0;
      if (sel == REQ_DATA && fetch_pending)
         nxt = (cur == STREAK_LIMIT) ? STREAK_LIMIT : cur + 1'b1;
      return nxt;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_arb.sv
// Grant decision between fetch and data requesters, with the data-streak
// counter that keeps a pending fetch from starving behind back-to-back data.
module mem_port_arbiter_arb
   import mem_port_arbiter_pkg::*;
(
   input  logic     clk,
   input  logic     reset_n,
   input  logic     arb_en,
   input  logic     f_req,
   input  logic     d_req,
   output logic     grant,
   output req_sel_t grant_sel
);

   logic [STREAK_W-1:0] dstreak;
   logic                data_win;

   always_comb begin
      data_win  = d_req & ~(f_req & (dstreak == STREAK_LIMIT));
      grant     = arb_en & (f_req | d_req);
      grant_sel = data_win ? REQ_DATA : REQ_FETCH;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         dstreak <= '0;
      else if (grant)
         dstreak <= streak_next(dstreak, grant_sel, f_req);
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Each grant runs a fixed-latency access followed by a one-cycle done pulse.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | arbitrate; a grant latches requester, address, we, wdata
// ST_ACCESS | readM or writeM held for MEM_LATENCY cycles (down-counter)
// ST_DONE   | strobes low, done pulse to the winning requester
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int WORD_SIZE   = WORD_SIZE_DEF,
   parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 f_req,
   input  logic [WORD_SIZE-1:0] f_addr,
   output logic                 f_done,
   output logic [WORD_SIZE-1:0] f_rdata,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [WORD_SIZE-1:0] d_addr,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic                 d_done,
   output logic [WORD_SIZE-1:0] d_rdata,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] address,
   inout  wire  [WORD_SIZE-1:0] data,
   output logic                 busy
);

   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   arb_state_t           state;
   arb_state_t           state_nxt;
   logic                 grant;
   req_sel_t             grant_sel;
   req_sel_t             sel_q;
   logic                 we_q;
   logic [WORD_SIZE-1:0] wdata_q;
   logic [CNT_W-1:0]     cnt;
   logic                 cnt_tc;
   logic                 last_access;
   logic                 acc_we;
   logic                 readm_nxt;
   logic                 writem_nxt;
   logic                 f_done_nxt;
   logic                 d_done_nxt;

   mem_port_arbiter_arb u_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .arb_en    (state == ST_IDLE),
      .f_req     (f_req),
      .d_req     (d_req),
      .grant     (grant),
      .grant_sel (grant_sel)
   );

   assign cnt_tc      = (cnt == '0);
   assign last_access = (state == ST_ACCESS) && cnt_tc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (grant) state_nxt = ST_ACCESS;
         ST_ACCESS: if (cnt_tc) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Strobes are computed one cycle ahead so the port outputs come straight from flops.
   always_comb begin
      acc_we     = grant ? ((grant_sel == REQ_DATA) && d_we) : we_q;
      readm_nxt  = (state_nxt == ST_ACCESS) && !acc_we;
      writem_nxt = (state_nxt == ST_ACCESS) && acc_we;
      f_done_nxt = last_access && (sel_q == REQ_FETCH);
      d_done_nxt = last_access && (sel_q == REQ_DATA);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readM  <= 1'b0;
         writeM <= 1'b0;
         f_done <= 1'b0;
         d_done <= 1'b0;
      end else begin
         readM  <= readm_nxt;
         writeM <= writem_nxt;
         f_done <= f_done_nxt;
         d_done <= d_done_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_q   <= REQ_FETCH;
         we_q    <= 1'b0;
         wdata_q <= '0;
         address <= '0;
         cnt     <= '0;
      end else if (grant) begin
         sel_q   <= grant_sel;
         we_q    <= (grant_sel == REQ_DATA) && d_we;
         wdata_q <= d_wdata;
         address <= (grant_sel == REQ_DATA) ? d_addr : f_addr;
         cnt     <= CNT_LOAD;
      end else if ((state == ST_ACCESS) && !cnt_tc) begin
         cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         f_rdata <= '0;
         d_rdata <= '0;
      end else if (last_access && !we_q) begin
         if (sel_q == REQ_FETCH)
            f_rdata <= data;
         else
            d_rdata <= data;
      end
   end

   assign data = writeM ? wdata_q : {WORD_SIZE{1'bz}};
   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed vector table, hand sequences for arbitration,
// starvation and reset-abort, then random traffic against a schedule model.
module tb_mem_port_arbiter;

   localparam int W = 16;
   localparam int L = 2;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         f_req, d_req, d_we;
   logic [W-1:0] f_addr, d_addr, d_wdata;
   logic         f_done, d_done, readM, writeM, busy;
   logic [W-1:0] f_rdata, d_rdata, address;
   wire  [W-1:0] data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(L)) dut (
      .clk(clk), .reset_n(reset_n),
      .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .readM(readM), .writeM(writeM), .address(address), .data(data),
      .busy(busy)
   );

   // simple 256-word memory on the bus
   logic [W-1:0] mem [0:255];
   logic         mem_clr;
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else if (writeM) begin
         mem[address[7:0]] <= data;
      end
   end
   assign data = readM ? mem[address[7:0]] : {W{1'bz}};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model for the random phase ----------------
   logic         model_en = 1'b0;
   int           cyc, next_free, m_g;
   logic         m_valid, m_is_d, m_we;
   logic [W-1:0] m_addr, m_wdata, m_exp;
   int           streak;
   logic [W-1:0] shadow [0:255];

   always @(posedge clk) begin
      if (!model_en) begin
         cyc <= 0; next_free <= 0; m_g <= 0; m_valid <= 1'b0; streak <= 0;
         m_is_d <= 1'b0; m_we <= 1'b0; m_addr <= '0; m_wdata <= '0; m_exp <= '0;
         for (int i = 0; i < 256; i++) shadow[i] <= '0;
      end else begin
         cyc <= cyc + 1;
         if (cyc + 1 >= next_free && (f_req || d_req)) begin
            if (d_req && !(f_req && streak == 2)) begin
               m_is_d  <= 1'b1;
               m_we    <= d_we;
               m_addr  <= d_addr;
               m_wdata <= d_wdata;
               streak  <= f_req ? ((streak >= 2) ? 2 : streak + 1) : 0;
               if (d_we) shadow[d_addr[7:0]] <= d_wdata;
               else      m_exp <= shadow[d_addr[7:0]];
            end else begin
               m_is_d <= 1'b0;
               m_we   <= 1'b0;
               m_addr <= f_addr;
               streak <= 0;
               m_exp  <= shadow[f_addr[7:0]];
            end
            m_g       <= cyc + 1;
            m_valid   <= 1'b1;
            next_free <= cyc + 1 + L + 2;
         end
      end
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      bit           is_d;
      bit           we;
      logic [W-1:0] addr;
      logic [W-1:0] wdata;
      logic [W-1:0] exp_rd;
   } vec_t;

   vec_t vecs [8];

   task automatic run_vec(input vec_t v, input int idx);
      int  n, strobes;
      bit  got;
      @(negedge clk);
      if (v.is_d) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         f_req = 1'b1; f_addr = v.addr;
      end
      n = 0; strobes = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (readM || writeM) begin
            strobes++;
            check($sformatf("v%0d_address", idx), address, v.addr);
            check($sformatf("v%0d_writeM", idx), writeM, v.we);
            if (writeM) check($sformatf("v%0d_bus_wdata", idx), data, v.wdata);
         end
         got = v.is_d ? d_done : f_done;
         if (got) check($sformatf("v%0d_other_done", idx), v.is_d ? f_done : d_done, 1'b0);
      end
      check($sformatf("v%0d_done_seen", idx), got, 1'b1);
      check($sformatf("v%0d_latency", idx), n, L + 1);
      check($sformatf("v%0d_strobe_cycles", idx), strobes, L);
      if (!v.we) check($sformatf("v%0d_rdata", idx), v.is_d ? d_rdata : f_rdata, v.exp_rd);
      f_req = 1'b0; d_req = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin : main
      int     n, fd_n, dd_n, nd;
      bit     got;
      bit     order [$];
      bit     exp_order [6];

      vecs[0] = '{1, 1, 16'h0010, 16'h1234, 16'h0000};
      vecs[1] = '{0, 0, 16'h0010, 16'h0000, 16'h1234};
      vecs[2] = '{1, 1, 16'h0020, 16'hBEEF, 16'h0000};
      vecs[3] = '{1, 0, 16'h0020, 16'h0000, 16'hBEEF};
      vecs[4] = '{1, 1, 16'h00FF, 16'hFFFF, 16'h0000};
      vecs[5] = '{0, 0, 16'h00FF, 16'h0000, 16'hFFFF};
      vecs[6] = '{1, 1, 16'h0000, 16'hA5A5, 16'h0000};
      vecs[7] = '{1, 0, 16'h0000, 16'h0000, 16'hA5A5};
      exp_order = '{1, 1, 0, 1, 1, 0};

      reset_n = 1'b0; mem_clr = 1'b1;
      f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      f_addr = '0; d_addr = '0; d_wdata = '0;
      @(negedge clk); @(negedge clk);
      check("rst_readM", readM, 0);
      check("rst_writeM", writeM, 0);
      check("rst_address", address, 0);
      check("rst_busy", busy, 0);
      check("rst_f_done", f_done, 0);
      check("rst_d_done", d_done, 0);
      check("rst_f_rdata", f_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      mem_clr = 1'b0;
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // simultaneous requests: data first, fetch right after the DONE cycle
      @(negedge clk);
      f_req = 1'b1; f_addr = 16'h0010;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
      n = 0; fd_n = 0; dd_n = 0;
      while (fd_n == 0 && n < 30) begin
         @(negedge clk);
         n++;
         if (d_done && dd_n == 0) begin dd_n = n; d_req = 1'b0; end
         if (f_done) fd_n = n;
      end
      check("sim_d_first_latency", dd_n, L + 1);
      check("sim_f_latency", fd_n, 2 * (L + 2) - 1);
      check("sim_d_rdata", d_rdata, 16'hBEEF);
      check("sim_f_rdata", f_rdata, 16'h1234);
      f_req = 1'b0;

      // starvation guard: both held continuously
      @(negedge clk);
      f_req = 1'b1; f_addr = 16'h0010;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
      n = 0;
      while (order.size() < 6 && n < 80) begin
         @(negedge clk);
         n++;
         if (d_done) order.push_back(1'b1);
         if (f_done) order.push_back(1'b0);
      end
      f_req = 1'b0; d_req = 1'b0;
      check("starve_grant_count", order.size(), 6);
      for (int i = 0; i < 6 && i < order.size(); i++)
         check($sformatf("starve_grant%0d_is_data", i), order[i], exp_order[i]);

      // reset during the second ACCESS cycle aborts without a done pulse
      @(negedge clk);
      f_req = 1'b1; f_addr = 16'h0010;
      @(negedge clk);
      @(negedge clk);
      check("abort_in_access", readM, 1);
      reset_n = 1'b0;
      #1;
      check("abort_readM", readM, 0);
      check("abort_busy", busy, 0);
      check("abort_address", address, 0);
      @(negedge clk);
      check("abort_no_f_done", f_done, 0);
      check("abort_f_rdata_cleared", f_rdata, 0);
      reset_n = 1'b1;
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         got = f_done;
      end
      check("restart_latency", n, L + 1);
      check("restart_f_rdata", f_rdata, 16'h1234);
      f_req = 1'b0;

      // random traffic against the schedule model
      @(negedge clk);
      reset_n = 1'b0; mem_clr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      mem_clr = 1'b0; reset_n = 1'b1; model_en = 1'b1;
      for (int t = 0; t < 800; t++) begin
         @(negedge clk);
         nd = cyc - m_g;
         check("rnd_readM", readM, m_valid && nd < L && !m_we);
         check("rnd_writeM", writeM, m_valid && nd < L && m_we);
         check("rnd_busy", busy, m_valid && nd <= L);
         check("rnd_f_done", f_done, m_valid && nd == L && !m_is_d);
         check("rnd_d_done", d_done, m_valid && nd == L && m_is_d);
         if (m_valid && nd < L) check("rnd_address", address, m_addr);
         if (m_valid && nd < L && m_we) check("rnd_bus_wdata", data, m_wdata);
         if (m_valid && nd == L && !m_we)
            check("rnd_rdata", m_is_d ? d_rdata : f_rdata, m_exp);

         if (f_req && f_done) begin
            if ($urandom_range(1, 0) == 0) f_req = 1'b0;
            else f_addr = W'($urandom_range(255, 0));
         end else if (!f_req && $urandom_range(2, 0) == 0) begin
            f_req = 1'b1; f_addr = W'($urandom_range(255, 0));
         end
         if (d_req && d_done) begin
            if ($urandom_range(1, 0) == 0) d_req = 1'b0;
            else begin
               d_we = 1'($urandom_range(1, 0));
               d_addr = W'($urandom_range(255, 0));
               d_wdata = W'($urandom);
            end
         end else if (!d_req && $urandom_range(2, 0) == 0) begin
            d_req = 1'b1;
            d_we = 1'($urandom_range(1, 0));
            d_addr = W'($urandom_range(255, 0));
            d_wdata = W'($urandom);
         end
      end
      f_req = 1'b0; d_req = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
